nco_cfg_write_arbiter: RTL and testbench
========================================

// Module: nco_cfg_write_arbiter
// PURPOSE
//  AXI4-Lite write master that shares the NCO CFO compensator control port between two requesters.
//  Req0 is the CFO estimator (frequency-word updates, latest-value-wins). Req1 is the host/CPU register bridge (arbitrary writes).
//  Sits between those sources and the frontend's s_axi_* NCO port. Serialises writes with one transaction outstanding.
//  Reports each transaction's BRESP back to the issuing requester.
// PARAMETERS
//  ADDR_WIDTH     4      AXI4-Lite address width (matches NCO control port)
//  DATA_WIDTH     32     AXI4-Lite data width
//  FREQ_ADDR      4'h0   NCO phase-increment register address used for req0 writes
//  ROUND_ROBIN    1      1: alternate grant on contention; 0: fixed priority, req0 wins
// PORTS
//  clk               in   1           system clock
//  rst_n             in   1           asynchronous active-low reset
//  est_freq          in   DATA_WIDTH  req0 phase-increment word
//  est_valid         in   1           req0 update strobe (always accepted)
//  est_done          out  1           1-cycle pulse: req0 write completed
//  host_awaddr       in   ADDR_WIDTH  req1 write address
//  host_wdata        in   DATA_WIDTH  req1 write data
//  host_wstrb        in   4           req1 byte strobes
//  host_valid        in   1           req1 request valid (held until host_ready)
//  host_ready        out  1           req1 request accepted
//  host_done         out  1           1-cycle pulse: req1 write completed
//  done_resp         out  2           BRESP of the completing transaction (valid with *_done)
//  m_axi_awvalid/awready/awaddr       AXI4-Lite AW channel (master side)
//  m_axi_wvalid/wready/wdata/wstrb    AXI4-Lite W channel
//  m_axi_bvalid/bready/bresp          AXI4-Lite B channel
//  busy              out  1           transaction in flight
// BEHAVIOUR
//  Reset state: every output is 0. FSM is IDLE, est_pend=0, rr_last=1 (first contended grant goes to req0).
//  Req0 shadow register: est_valid=1 loads est_freq into shadow and sets est_pend in the same cycle.
//   - No ready signal; the newest value overwrites any pending, unissued value (coalescing).
//   - If est_valid coincides with the cycle that captures the shadow for issue: the new value is kept and est_pend stays 1.
//  FSM states:
//   - IDLE: if est_pend or host_valid, grant one and go to ADDR. Grant is registered.
//     Contention: ROUND_ROBIN=1 grants the requester that was not rr_last; ROUND_ROBIN=0 grants req0.
//     Granting req1 pulses host_ready in the IDLE->ADDR cycle and latches host addr/data/strb.
//     Granting req0 latches shadow (addr=FREQ_ADDR, strb=4'hF) and clears est_pend, except as noted above.
//   - ADDR: awvalid and wvalid assert together one cycle after grant. Each drops independently on its own handshake.
//     Both handshakes may complete in the same or in different cycles. Move to RESP when both are done.
//     awaddr/wdata/wstrb are stable while the corresponding valid is high.
//   - RESP: bready=1. On bvalid: pulse est_done or host_done and present done_resp=bresp (same cycle, registered). Update rr_last, return to IDLE.
//  Latency: grant->awvalid is 1 cycle. Idle with a pending request to awvalid is 2 cycles. A new grant can occur the cycle after RESP exits.
//  Minimum 4 cycles per transaction with a zero-wait slave.
//  No timeout: RESP waits indefinitely (AXI forbids abandoning). busy=1 in ADDR and RESP.
//  bresp is not acted on: SLVERR/DECERR is only forwarded via done_resp. No automatic retry.
//  rst_n assert mid-transaction: async clear to IDLE and all valids 0. The pending estimate is discarded.
//   The slave must be reset by the same rst_n.
//  AXI rules: valids never depend combinationally on readies. No read channel (host reads go direct).
// STRUCTURE
//  Shared package ofdm_frontend_pkg: typedef enum {IDLE, ADDR, RESP} axil_wr_state_e; AXIL_RESP_OKAY/SLVERR/DECERR constants; NCO register address localparams (FREQ_ADDR source).
//  Single module; optional sub-module rr_arbiter2 (2-way round-robin grant with last-grant register) reused by later arbiters.
// TESTING
//  1. est_valid with 0x01000000, slave zero-wait -> awaddr=0 wdata=0x01000000 wstrb=F; est_done 4 cycles after strobe; done_resp=0.
//  2. 3 est_valid pulses (0x10,0x20,0x30) during a host write in flight -> exactly one req0 write follows, wdata=0x30.
//  3. host_valid and est_pend both high in IDLE, ROUND_ROBIN=1, 4 back-to-back each -> grants alternate req0,req1,req0,...; ROUND_ROBIN=0 -> all req0 first.
//  4. Slave delays awready 3 cycles and wready 0 cycles -> wvalid drops after 1 cycle, awvalid held 4 cycles with stable awaddr; single B handshake.
//  5. Slave returns bresp=2'b10 on host write -> host_done pulse with done_resp=2'b10; next request proceeds normally.
//  6. rst_n low while in RESP with est_pend=1 -> all outputs 0 asynchronously; after release no write issued until new request.

Source files
------------

// File: rtl/ofdm_frontend_pkg.sv
// Shared OFDM frontend definitions: AXI4-Lite write FSM states, response codes
// and the NCO control-port register map.
package ofdm_frontend_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2
  } axil_wr_state_e;

  localparam logic [1:0] AXIL_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXIL_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXIL_RESP_DECERR = 2'b11;

  // NCO control-port register map
  localparam logic [3:0] NCO_REG_FREQ  = 4'h0;
  localparam logic [3:0] NCO_REG_PHASE = 4'h4;
  localparam logic [3:0] NCO_REG_CTRL  = 4'h8;

  localparam logic [3:0] AXIL_STRB_ALL = 4'hF;

endpackage

// File: rtl/nco_cfg_write_arbiter_rr_arbiter2.sv
// Two-way arbiter with a last-grant register; round-robin or fixed priority
// (requester 0 wins) on contention.
module rr_arbiter2 #(
  parameter int unsigned ROUND_ROBIN = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  input  logic upd,
  input  logic upd_id,
  output logic gnt_valid,
  output logic gnt_id
);

  // Reset to 1 so the first contended grant goes to requester 0
  logic last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else if (upd) begin
      last_q <= upd_id;
    end
  end

  always_comb begin
    gnt_valid = req0 | req1;
    gnt_id    = 1'b0;
    if (req0 && req1) begin
      gnt_id = (ROUND_ROBIN != 0) ? ~last_q : 1'b0;
    end else if (req1) begin
      gnt_id = 1'b1;
    end
  end

endmodule

// File: rtl/nco_cfg_write_arbiter.sv
// AXI4-Lite write master sharing the NCO control port between the CFO
// estimator (coalesced frequency updates) and the host register bridge.
module nco_cfg_write_arbiter
  import ofdm_frontend_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 4,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] FREQ_ADDR = ADDR_WIDTH'(NCO_REG_FREQ),
  parameter int unsigned ROUND_ROBIN = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] est_freq,
  input  logic                  est_valid,
  output logic                  est_done,
  input  logic [ADDR_WIDTH-1:0] host_awaddr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  input  logic [3:0]            host_wstrb,
  input  logic                  host_valid,
  output logic                  host_ready,
  output logic                  host_done,
  output logic [1:0]            done_resp,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  output logic [DATA_WIDTH-1:0] m_axi_wdata,
  output logic [3:0]            m_axi_wstrb,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  input  logic [1:0]            m_axi_bresp,
  output logic                  busy
);

  axil_wr_state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] shadow_q;
  logic                  est_pend_q;
  logic                  cur_id_q;
  logic                  issue_q;
  logic                  grant;
  logic                  finish;
  logic                  gnt_valid;
  logic                  gnt_id;
  logic                  aw_clear;
  logic                  w_clear;

  rr_arbiter2 #(
    .ROUND_ROBIN (ROUND_ROBIN)
  ) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .req0      (est_pend_q),
    .req1      (host_valid),
    .upd       (finish),
    .upd_id    (cur_id_q),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  assign aw_clear = !m_axi_awvalid || m_axi_awready;
  assign w_clear  = !m_axi_wvalid  || m_axi_wready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          grant   = 1'b1;
          state_d = ADDR;
        end
      end
      ADDR: begin
        // issue_q holds off the exit until the valids have actually gone out
        if (!issue_q && aw_clear && w_clear) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (m_axi_bvalid) begin
          finish  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q      <= '0;
      est_pend_q    <= 1'b0;
      cur_id_q      <= 1'b0;
      issue_q       <= 1'b0;
      host_ready    <= 1'b0;
      est_done      <= 1'b0;
      host_done     <= 1'b0;
      done_resp     <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_awaddr  <= '0;
      m_axi_wvalid  <= 1'b0;
      m_axi_wdata   <= '0;
      m_axi_wstrb   <= '0;
      m_axi_bready  <= 1'b0;
      busy          <= 1'b0;
    end else begin
      host_ready <= 1'b0;
      est_done   <= finish & ~cur_id_q;
      host_done  <= finish &  cur_id_q;
      done_resp  <= finish ? m_axi_bresp : AXIL_RESP_OKAY;

      // A strobe in the capture cycle wins: the new value stays pending
      if (est_valid) begin
        shadow_q   <= est_freq;
        est_pend_q <= 1'b1;
      end else if (grant && !gnt_id) begin
        est_pend_q <= 1'b0;
      end

      if (grant) begin
        cur_id_q <= gnt_id;
        issue_q  <= 1'b1;
        if (gnt_id) begin
          host_ready   <= 1'b1;
          m_axi_awaddr <= host_awaddr;
          m_axi_wdata  <= host_wdata;
          m_axi_wstrb  <= host_wstrb;
        end else begin
          m_axi_awaddr <= FREQ_ADDR;
          m_axi_wdata  <= shadow_q;
          m_axi_wstrb  <= AXIL_STRB_ALL;
        end
      end

      if (state_q == ADDR) begin
        if (issue_q) begin
          m_axi_awvalid <= 1'b1;
          m_axi_wvalid  <= 1'b1;
          issue_q       <= 1'b0;
        end else begin
          if (m_axi_awready) m_axi_awvalid <= 1'b0;
          if (m_axi_wready)  m_axi_wvalid  <= 1'b0;
        end
      end

      m_axi_bready <= (state_d == RESP);
      busy         <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_nco_cfg_write_arbiter.sv
// Directed bench: a round-robin instance with a configurable slave and a
// fixed-priority instance with a zero-wait slave.
module tb_nco_cfg_write_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  // Round-robin instance
  logic [31:0] est_freq = '0;
  logic        est_valid = 1'b0;
  logic        est_done;
  logic [3:0]  host_awaddr = '0;
  logic [31:0] host_wdata = '0;
  logic [3:0]  host_wstrb = '0;
  logic        host_valid = 1'b0;
  logic        host_ready, host_done;
  logic [1:0]  done_resp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready, busy;
  logic [3:0]  awaddr, wstrb;
  logic [31:0] wdata;
  logic [1:0]  bresp;

  // Fixed-priority instance
  logic [31:0] f_est_freq = 32'h0000_0042;
  logic        f_est_valid = 1'b0;
  logic        f_est_done;
  logic [3:0]  f_host_awaddr = 4'h4;
  logic [31:0] f_host_wdata = 32'h0000_1111;
  logic [3:0]  f_host_wstrb = 4'hF;
  logic        f_host_valid = 1'b0;
  logic        f_host_ready, f_host_done;
  logic [1:0]  f_done_resp;
  logic        f_awvalid, f_awready, f_wvalid, f_wready, f_bvalid, f_bready, f_busy;
  logic [3:0]  f_awaddr, f_wstrb;
  logic [31:0] f_wdata;
  logic [1:0]  f_bresp = 2'b00;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  nco_cfg_write_arbiter #(.ROUND_ROBIN(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .est_freq(est_freq), .est_valid(est_valid), .est_done(est_done),
    .host_awaddr(host_awaddr), .host_wdata(host_wdata), .host_wstrb(host_wstrb),
    .host_valid(host_valid), .host_ready(host_ready), .host_done(host_done),
    .done_resp(done_resp),
    .m_axi_awvalid(awvalid), .m_axi_awready(awready), .m_axi_awaddr(awaddr),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
    .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_bresp(bresp),
    .busy(busy)
  );

  nco_cfg_write_arbiter #(.ROUND_ROBIN(0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .est_freq(f_est_freq), .est_valid(f_est_valid), .est_done(f_est_done),
    .host_awaddr(f_host_awaddr), .host_wdata(f_host_wdata), .host_wstrb(f_host_wstrb),
    .host_valid(f_host_valid), .host_ready(f_host_ready), .host_done(f_host_done),
    .done_resp(f_done_resp),
    .m_axi_awvalid(f_awvalid), .m_axi_awready(f_awready), .m_axi_awaddr(f_awaddr),
    .m_axi_wvalid(f_wvalid), .m_axi_wready(f_wready), .m_axi_wdata(f_wdata), .m_axi_wstrb(f_wstrb),
    .m_axi_bvalid(f_bvalid), .m_axi_bready(f_bready), .m_axi_bresp(f_bresp),
    .busy(f_busy)
  );

  // Configurable slave for the round-robin instance
  logic [3:0] aw_dly = '0, w_dly = '0;
  logic [3:0] aw_wait, w_wait;
  logic       aw_got, w_got, aw_now, w_now;
  logic       b_stall = 1'b0;
  logic [1:0] bresp_cfg = 2'b00;

  assign awready = awvalid && (aw_wait >= aw_dly);
  assign wready  = wvalid  && (w_wait  >= w_dly);
  assign aw_now  = aw_got || (awvalid && awready);
  assign w_now   = w_got  || (wvalid  && wready);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_wait <= '0; w_wait <= '0; aw_got <= 1'b0; w_got <= 1'b0;
      bvalid <= 1'b0; bresp <= 2'b00;
    end else begin
      aw_wait <= (awvalid && !awready) ? aw_wait + 4'd1 : 4'd0;
      w_wait  <= (wvalid  && !wready)  ? w_wait  + 4'd1 : 4'd0;
      if (bvalid && bready) bvalid <= 1'b0;
      if (aw_now && w_now && !bvalid && !b_stall) begin
        bvalid <= 1'b1; bresp <= bresp_cfg; aw_got <= 1'b0; w_got <= 1'b0;
      end else begin
        aw_got <= aw_now; w_got <= w_now;
      end
    end
  end

  // Zero-wait slave for the fixed-priority instance
  assign f_awready = f_awvalid;
  assign f_wready  = f_wvalid;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) f_bvalid <= 1'b0;
    else if (f_awvalid && f_wvalid) f_bvalid <= 1'b1;
    else if (f_bready) f_bvalid <= 1'b0;
  end

  // Monitors (sampled mid-cycle)
  logic       done_log[$];
  logic [1:0] resp_log[$];
  logic       f_done_log[$];
  int n_aw = 0, n_b = 0, aw_hi = 0, w_hi = 0, aw_unstable = 0;
  logic [3:0]  last_awaddr = '0, last_wstrb = '0, aw_prev_addr = '0;
  logic [31:0] last_wdata = '0;
  logic        aw_prev_valid = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (est_done || host_done) begin
        done_log.push_back(host_done);
        resp_log.push_back(done_resp);
      end
      if (f_est_done || f_host_done) f_done_log.push_back(f_host_done);
      if (awvalid) begin
        aw_hi++;
        if (aw_prev_valid && awaddr != aw_prev_addr) aw_unstable++;
        if (awready) begin n_aw++; last_awaddr = awaddr; end
      end
      if (wvalid) begin
        w_hi++;
        if (wready) begin last_wdata = wdata; last_wstrb = wstrb; end
      end
      if (bvalid && bready) n_b++;
      aw_prev_valid = awvalid;
      aw_prev_addr  = awaddr;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_log(input string tag, input int target);
    int b = 0;
    while (done_log.size() < target && b < 300) begin
      @(negedge clk);
      b++;
    end
    chk(tag, done_log.size(), target);
  endtask

  // Caller sits at a negedge; returns at the negedge where host_ready is seen
  task automatic host_req(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    int b = 0;
    host_awaddr = a; host_wdata = d; host_wstrb = s; host_valid = 1'b1;
    do begin
      @(negedge clk);
      b++;
    end while (!host_ready && b < 100);
    chk("host_ready_seen", host_ready, 1'b1);
    host_valid = 1'b0;
  endtask

  function automatic logic [63:0] outs_vec();
    return {15'd0, awvalid, wvalid, bready, busy, host_ready, est_done, host_done,
            done_resp, awaddr, wdata, wstrb};
  endfunction

  initial begin
    int base;
    int cnt;
    int b;
    int hosts;
    int est_after;
    logic seen_host;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_outs", outs_vec(), 64'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_outs", outs_vec(), 64'd0);

    // 1: single estimator update, zero-wait slave, exact latency
    est_freq = 32'h0100_0000; est_valid = 1'b1;
    @(negedge clk);
    est_valid = 1'b0;
    @(negedge clk); chk("t1_aw_c1", awvalid, 1'b0);
    @(negedge clk); chk("t1_aw_c2", awvalid, 1'b1);
    @(negedge clk); chk("t1_done_c3", est_done, 1'b0);
    @(negedge clk); chk("t1_done_c4", est_done, 1'b1);
    chk("t1_resp", done_resp, 2'b00);
    chk("t1_hdone", host_done, 1'b0);
    @(negedge clk); chk("t1_done_c5", est_done, 1'b0);
    chk("t1_awaddr", last_awaddr, 4'h0);
    chk("t1_wdata", last_wdata, 32'h0100_0000);
    chk("t1_wstrb", last_wstrb, 4'hF);

    // 2: three updates during a host write coalesce into one write
    host_req(4'h4, 32'hAABB_CCDD, 4'hF);
    est_valid = 1'b1; est_freq = 32'h10;
    @(negedge clk); est_freq = 32'h20;
    @(negedge clk); est_freq = 32'h30;
    @(negedge clk); est_valid = 1'b0;
    wait_log("t2_log", 3);
    repeat (12) @(negedge clk);
    chk("t2_log_after", done_log.size(), 3);
    chk("t2_order_host", done_log[1], 1'b1);
    chk("t2_order_est", done_log[2], 1'b0);
    chk("t2_n_aw", n_aw, 3);
    chk("t2_wdata", last_wdata, 32'h30);
    chk("t2_awaddr", last_awaddr, 4'h0);

    // 4: slow awready, immediate wready
    aw_dly = 4'd3; w_dly = 4'd0;
    aw_hi = 0; w_hi = 0; aw_unstable = 0; n_b = 0;
    host_req(4'h8, 32'h1234_5678, 4'b0011);
    wait_log("t4_log", 4);
    repeat (3) @(negedge clk);
    chk("t4_aw_hi", aw_hi, 4);
    chk("t4_w_hi", w_hi, 1);
    chk("t4_aw_stable", aw_unstable, 0);
    chk("t4_n_b", n_b, 1);
    chk("t4_awaddr", last_awaddr, 4'h8);
    chk("t4_wdata", last_wdata, 32'h1234_5678);
    chk("t4_wstrb", last_wstrb, 4'b0011);
    chk("t4_resp", resp_log[3], 2'b00);
    aw_dly = 4'd0;

    // 5: SLVERR forwarded on host write, next request unaffected
    bresp_cfg = 2'b10;
    host_req(4'hC, 32'h5A5A_0001, 4'hF);
    wait_log("t5_log", 5);
    chk("t5_who", done_log[4], 1'b1);
    chk("t5_resp", resp_log[4], 2'b10);
    bresp_cfg = 2'b00;
    est_freq = 32'hCAFE_0000; est_valid = 1'b1;
    @(negedge clk); est_valid = 1'b0;
    wait_log("t5_next_log", 6);
    chk("t5_next_who", done_log[5], 1'b0);
    chk("t5_next_resp", resp_log[5], 2'b00);
    chk("t5_next_wdata", last_wdata, 32'hCAFE_0000);

    // 6: reset while waiting in RESP with an estimate pending
    b_stall = 1'b1;
    host_req(4'h4, 32'h0000_0077, 4'hF);
    est_freq = 32'h99; est_valid = 1'b1;
    @(negedge clk); est_valid = 1'b0;
    b = 0;
    while (!bready && b < 50) begin @(negedge clk); b++; end
    chk("t6_in_resp", bready, 1'b1);
    #2 rst_n = 1'b0;
    #1 chk("t6_async_clear", outs_vec(), 64'd0);
    @(negedge clk);
    b_stall = 1'b0;
    rst_n = 1'b1;
    base = done_log.size();
    cnt = n_aw;
    repeat (10) @(negedge clk);
    chk("t6_no_aw", n_aw, cnt);
    chk("t6_no_done", done_log.size(), base);
    chk("t6_busy", busy, 1'b0);

    // 3a: round-robin contention from reset
    base = done_log.size();
    est_freq = 32'h0000_0500; est_valid = 1'b1;
    @(negedge clk);
    host_awaddr = 4'h4; host_wdata = 32'h0000_0A00; host_wstrb = 4'hF; host_valid = 1'b1;
    cnt = 0; b = 0;
    while (cnt < 4 && b < 200) begin
      @(negedge clk);
      b++;
      if (host_ready) begin cnt++; host_wdata = host_wdata + 32'd1; end
    end
    host_valid = 1'b0; est_valid = 1'b0;
    chk("t3_host_acc", cnt, 4);
    wait_log("t3_log", base + 9);
    for (int i = 0; i < 8; i++) chk($sformatf("t3_rr_%0d", i), done_log[base + i], i[0]);

    // 3b: fixed priority, estimator wins while it keeps updating
    f_est_valid = 1'b1;
    fork
      begin
        repeat (14) @(negedge clk);
        f_est_valid = 1'b0;
      end
      begin
        int c = 0;
        int bb = 0;
        @(negedge clk);
        f_host_valid = 1'b1;
        while (c < 4 && bb < 300) begin
          @(negedge clk);
          bb++;
          if (f_host_ready) begin c++; f_host_wdata = f_host_wdata + 32'd1; end
        end
        f_host_valid = 1'b0;
        chk("t3_fp_host_acc", c, 4);
      end
    join
    b = 0;
    while (f_busy && b < 50) begin @(negedge clk); b++; end
    repeat (4) @(negedge clk);
    for (int i = 0; i < 4; i++) chk($sformatf("t3_fp_lead_%0d", i), f_done_log[i], 1'b0);
    hosts = 0; est_after = 0; seen_host = 1'b0;
    foreach (f_done_log[i]) begin
      if (f_done_log[i]) begin hosts++; seen_host = 1'b1; end
      else if (seen_host) est_after++;
    end
    chk("t3_fp_hosts", hosts, 4);
    chk("t3_fp_est_after_host", est_after, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
